// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the sequential CPU ALU: opcodes, FSM states, flag indices.
package cpu_alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_OR     = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd3;
  localparam logic [3:0] OP_EOR    = 4'd4;
  localparam logic [3:0] OP_ASL    = 4'd5;
  localparam logic [3:0] OP_LSR    = 4'd6;
  localparam logic [3:0] OP_ROL    = 4'd7;
  localparam logic [3:0] OP_ROR    = 4'd8;
  localparam logic [3:0] OP_INC    = 4'd9;
  localparam logic [3:0] OP_DEC    = 4'd10;
  localparam logic [3:0] OP_PASS_A = 4'd11;
  localparam logic [3:0] OP_PASS_B = 4'd12;
  localparam logic [3:0] OP_MUL    = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/cpu_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step, WIDTH steps.
module cpu_alu_mul_iter
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // partial is the accumulator after the current step, so the final step's value is the product
  always_comb begin
    partial  = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, b};
      mplier_d = a;
      cnt_d    = CW'(WIDTH - 1);
    end else if (step) begin
      acc_d    = partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  assign product = partial;
  assign last    = (cnt_q == '0);

endmodule

// File: rtl/cpu_alu_seq.sv
// Registered CPU ALU with carry-in, N/Z/C/V flags, rotates and an iterative multiply,
// driven by a start/busy/done handshake from the CPU control FSM.
module cpu_alu_seq
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             c_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  logic [3:0]         flags_q, flags_d;

  logic               accept, is_mul, mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  assign accept   = start && (state_q != ST_MUL);
  assign is_mul   = MUL_EN && (op == OP_MUL);
  assign mul_load = accept && is_mul;
  assign mul_step = (state_q == ST_MUL);

  cpu_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .step    (mul_step),
    .a       (A),
    .b       (B),
    .product (mul_product),
    .last    (mul_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      out_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      flags_q  <= flags_d;
    end
  end

  // DONE behaves like IDLE for acceptance so the control FSM can issue back-to-back
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = accept ? (is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
      ST_MUL:           if (mul_last) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // C and V default to their held values so ops that do not own them leave them alone
  always_comb begin
    sum     = '0;
    alu_res = A;
    alu_c   = flags_q[FLAG_C];
    alu_v   = flags_q[FLAG_V];
    case (op)
      OP_ADD: begin
        sum     = {1'b0, B} + {1'b0, A} + {{WIDTH{1'b0}}, c_in};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (B[MSB] == A[MSB]) && (alu_res[MSB] != B[MSB]);
      end
      OP_SUB: begin
        sum     = {1'b0, B} + {1'b0, ~A} + {{WIDTH{1'b0}}, c_in};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (B[MSB] != A[MSB]) && (alu_res[MSB] != B[MSB]);
      end
      OP_OR:     alu_res = B | A;
      OP_AND:    alu_res = B & A;
      OP_EOR:    alu_res = B ^ A;
      OP_ASL: begin
        alu_res = {B[MSB-1:0], 1'b0};
        alu_c   = B[MSB];
      end
      OP_LSR: begin
        alu_res = {1'b0, B[MSB:1]};
        alu_c   = B[0];
      end
      OP_ROL: begin
        alu_res = {B[MSB-1:0], c_in};
        alu_c   = B[MSB];
      end
      OP_ROR: begin
        alu_res = {c_in, B[MSB:1]};
        alu_c   = B[0];
      end
      OP_INC:    alu_res = B + WIDTH'(1);
      OP_DEC:    alu_res = B - WIDTH'(1);
      OP_PASS_B: alu_res = B;
      default:   alu_res = A;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    out_hi_d = out_hi_q;
    flags_d  = flags_q;
    if (accept && !is_mul) begin
      out_d           = alu_res;
      out_hi_d        = '0;
      flags_d[FLAG_N] = alu_res[MSB];
      flags_d[FLAG_Z] = (alu_res == '0);
      flags_d[FLAG_C] = alu_c;
      flags_d[FLAG_V] = alu_v;
    end else if (mul_step && mul_last) begin
      out_d           = mul_product[MSB:0];
      out_hi_d        = mul_product[2*WIDTH-1:WIDTH];
      flags_d[FLAG_N] = mul_product[2*WIDTH-1];
      flags_d[FLAG_Z] = (mul_product == '0);
      flags_d[FLAG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
    end
  end

  assign busy   = (state_q == ST_MUL);
  assign done   = (state_q == ST_DONE);
  assign out    = out_q;
  assign out_hi = out_hi_q;
  assign flag_n = flags_q[FLAG_N];
  assign flag_z = flags_q[FLAG_Z];
  assign flag_c = flags_q[FLAG_C];
  assign flag_v = flags_q[FLAG_V];

endmodule
